gf2_31_state_reg: RTL and testbench
===================================

// Module: gf2_31_state_reg
// PURPOSE
//   Recurrence state register of the GF(2^31) PRNG. Holds DEPTH 31-bit words,
//   packs them onto tap_vectors to feed xor_tree_5_31, and takes the tree result
//   back on fb_xor. Each step shifts fb_xor in and emits it via valid/ready.
//   Seeded by a word-serial load with all-zero seed rejection.
// PARAMETERS
//   WIDTH  31  bits per GF(2^31) element
//   DEPTH  5   state words; all DEPTH words are taps, so tap_vectors = DEPTH*WIDTH
// PORTS
//   clk          in   1            rising-edge clock
//   rst_n        in   1            async active-low reset
//   start        in   1            pulse: (re)enter LOAD from any state
//   seed_valid   in   1            seed word offered
//   seed_ready   out  1            seed word accepted when seed_valid&&seed_ready
//   seed_data    in   WIDTH        seed word
//   seed_err     out  1            sticky: last seed was all-zero
//   tap_vectors  out  DEPTH*WIDTH  {s[DEPTH-1],...,s[0]} to the XOR tree
//   fb_xor       in   WIDTH        XOR tree result (combinational from tap_vectors)
//   out_valid    out  1            out_data holds a fresh PRNG word
//   out_ready    in   1            consumer accepts out_data
//   out_data     out  WIDTH        newest state word s[0]
// BEHAVIOUR
//   Clock and reset: one clock clk. rst_n is asynchronous, active-low.
//   Reset: state=IDLE; s[*]=0; cnt=0. Outputs: seed_ready=0, seed_err=0,
//     out_valid=0, out_data=0.
//   Shift operation: s[0]<=X; s[i]<=s[i-1] for i=1..DEPTH-1.
//     X=seed_data during LOAD. X=fb_xor during PRIME/RUN.
//   States:
//   IDLE: seed_ready=0, out_valid=0. start -> LOAD.
//   LOAD: seed_ready=1. Each accepted seed word shifts in and increments cnt.
//     - The first accepted word ends up in s[DEPTH-1].
//     - On accept with cnt==DEPTH-1, cnt<=0, and the seed is checked.
//     - Zero check covers all DEPTH words, including the word being accepted.
//     - All-zero seed -> IDLE, seed_err<=1. Otherwise -> PRIME.
//   PRIME: exactly one cycle. Shift in fb_xor, out_valid<=1 -> RUN.
//     out_valid therefore rises 2 cycles after the final seed accept.
//   RUN: out_valid=1, out_data=s[0].
//     - out_valid&&out_ready: shift in fb_xor, so a new word appears next cycle.
//     - Back-to-back accepts give one word per cycle.
//     - out_ready=0: state, out_data and out_valid held stable (no drop, no dup).
//   start (any state, highest priority): next state LOAD.
//     - cnt<=0, seed_err<=0, out_valid<=0.
//     - s[*] retained until overwritten by seed words.
//     - A seed handshake in the same cycle as start is ignored; its word is
//       not shifted in.
//   seed_valid outside LOAD: ignored; seed_ready=0.
//   Width rules: pure GF(2) domain, no carries. All words are WIDTH bits.
//   Lock-up: a nonzero seed cannot reach the all-zero state. This holds given
//     an invertible recurrence, which is the generator's responsibility.
//   Reset mid-operation: async return to reset values on the same edge of
//     rst_n; leaving reset requires a new start.
// TESTING
//   Known vector, DEPTH=5, bench models the XOR tree.
//     Seed 958682846, 1051802512, 1181241943, 107420369, 478163327
//     -> 2 cycles after final accept: out_valid=1, out_data=31'd1528435895.
//   Stall: hold out_ready=0 for 10 cycles in RUN
//     -> out_data stays 1528435895, tap_vectors unchanged.
//     Then out_ready=1 for 3 cycles -> 3 distinct words, each matching the model.
//   Zero seed: five 31'd0 words -> seed_err=1, out_valid never rises, state IDLE.
//     Next start clears seed_err.
//   Restart mid-run: start during RUN with out_ready=1
//     -> out_valid=0 next cycle, seed_ready=1.
//     New seed 1,2,3,4,5 -> first out_data = 31'd1 (1^2^3^4^5).
//   Reset mid-load: drop rst_n after 3 seed words
//     -> all outputs at reset values immediately.
//     After release, seed_ready=0 until start.
//   Seed gaps: seed_valid toggling 1/0 -> only handshaken words counted.
//     Final output matches the known vector.

Source files
------------

// File: rtl/gf2_31_state_reg.sv
`default_nettype none
// ============================================================================
// Module   : gf2_31_state_reg
// Purpose  : Recurrence state register of the GF(2^31) PRNG. Keeps DEPTH
//            WIDTH-bit state words, presents all of them to the external XOR
//            tree and shifts the tree result (fb_xor) back in. Each shift
//            produces one PRNG word, handed out with a valid/ready handshake.
//            The state is seeded by a word-serial load, and an all-zero seed
//            is rejected.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            start                 (re)enter seed loading from any state
//            seed_valid/ready/data seed word handshake
//            seed_err              sticky, set when the last seed was all-zero
//            tap_vectors           {s[DEPTH-1],...,s[0]} to the XOR tree
//            fb_xor                XOR tree result
//            out_valid/ready/data  PRNG output handshake, data = s[0]
// Revision : 1.0  initial release
// ============================================================================
module gf2_31_state_reg #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  input  logic [WIDTH-1:0]       seed_data,
  output logic                   seed_err,
  output logic [DEPTH*WIDTH-1:0] tap_vectors,
  input  logic [WIDTH-1:0]       fb_xor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEPTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_PRIME = 2'd2;
  localparam logic [1:0] c_RUN   = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s [DEPTH];
  logic             r_seed_err;
  logic             r_out_valid;

  logic             w_seed_acc;
  logic             w_seed_zero;
  logic             w_shift;
  logic [WIDTH-1:0] w_x;

  // A seed handshake coinciding with start is discarded: start wins.
  assign w_seed_acc = (r_state == c_LOAD) && seed_valid && !start;

  // The seed being completed occupies s[DEPTH-2:0] plus the incoming word;
  // s[DEPTH-1] is about to be shifted out and is not part of it.
  always_comb begin
    w_seed_zero = (seed_data == '0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_seed_zero = w_seed_zero && (r_s[i] == '0);
    end
  end

  assign w_shift = !start && (w_seed_acc ||
                              (r_state == c_PRIME) ||
                              ((r_state == c_RUN) && r_out_valid && out_ready));

  assign w_x = (r_state == c_LOAD) ? seed_data : fb_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s[i] <= '0;
      end
    end else if (w_shift) begin
      r_s[0] <= w_x;
      for (int i = 1; i < DEPTH; i++) begin
        r_s[i] <= r_s[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_seed_err  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (start) begin
      r_state     <= c_LOAD;
      r_cnt       <= '0;
      r_seed_err  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_LOAD: begin
          if (w_seed_acc) begin
            if (r_cnt == c_CNT_LAST) begin
              r_cnt <= '0;
              if (w_seed_zero) begin
                r_state    <= c_IDLE;
                r_seed_err <= 1'b1;
              end else begin
                r_state <= c_PRIME;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_PRIME: begin
          r_state     <= c_RUN;
          r_out_valid <= 1'b1;
        end
        default: begin
          // IDLE waits for start; RUN holds until start or reset.
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign tap_vectors[g*WIDTH +: WIDTH] = r_s[g];
  end

  assign seed_ready = (r_state == c_LOAD);
  assign seed_err   = r_seed_err;
  assign out_valid  = r_out_valid;
  assign out_data   = r_s[0];

endmodule
`default_nettype wire

// File: tb/tb_gf2_31_state_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf2_31_state_reg
// Purpose  : Self-checking bench for gf2_31_state_reg. Models the XOR tree
//            and keeps a reference history of PRNG words in a queue, where
//            each new word is the XOR of the previous five.
// Revision : 1.0  initial release
// ============================================================================
module tb_gf2_31_state_reg;

  localparam int WIDTH = 31;
  localparam int DEPTH = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   seed_valid = 1'b0;
  logic                   seed_ready;
  logic [WIDTH-1:0]       seed_data = '0;
  logic                   seed_err;
  logic [DEPTH*WIDTH-1:0] tap_vectors;
  logic [WIDTH-1:0]       fb_xor;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [WIDTH-1:0]       out_data;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] hist [$];

  gf2_31_state_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .seed_err   (seed_err),
    .tap_vectors(tap_vectors),
    .fb_xor     (fb_xor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // XOR tree model.
  always_comb begin
    fb_xor = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fb_xor = fb_xor ^ tap_vectors[i*WIDTH +: WIDTH];
    end
  end

  typedef struct {
    logic [DEPTH*WIDTH-1:0] seeds;  // word k at [k*WIDTH +: WIDTH], k=0 first
    logic [WIDTH-1:0]       first;
    bit                     err;
  } vec_t;

  task automatic chk(input string nm, input logic [DEPTH*WIDTH-1:0] act,
                     input logic [DEPTH*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] next_word();
    logic [WIDTH-1:0] x = '0;
    for (int i = hist.size() - DEPTH; i < hist.size(); i++) x = x ^ hist[i];
    return x;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] exp_taps();
    logic [DEPTH*WIDTH-1:0] t = '0;
    for (int i = 0; i < DEPTH; i++) t[i*WIDTH +: WIDTH] = hist[hist.size()-1-i];
    return t;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    hist.delete();
    chk("seed_ready_after_start", 155'(seed_ready), 155'(1));
    chk("seed_err_after_start", 155'(seed_err), 155'(0));
    chk("out_valid_after_start", 155'(out_valid), 155'(0));
  endtask

  task automatic feed_word(input logic [WIDTH-1:0] w);
    seed_valid = 1'b1;
    seed_data  = w;
    tick();
    seed_valid = 1'b0;
    seed_data  = WIDTH'($urandom);
    hist.push_back(w);
  endtask

  task automatic load_seed(input logic [DEPTH*WIDTH-1:0] s, input bit gaps);
    pulse_start();
    for (int k = 0; k < DEPTH; k++) begin
      if (gaps) begin
        int n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          seed_valid = 1'b0;
          seed_data  = WIDTH'($urandom);
          tick();
          chk("seed_ready_in_gap", 155'(seed_ready), 155'(1));
        end
      end
      feed_word(s[k*WIDTH +: WIDTH]);
    end
  endtask

  // From PRIME: cross into RUN and check the first word.
  task automatic enter_run();
    chk("prime_out_valid", 155'(out_valid), 155'(0));
    tick();
    hist.push_back(next_word());
    chk("first_out_valid", 155'(out_valid), 155'(1));
    chk("first_out_data_model", 155'(out_data), 155'(hist[$]));
  endtask

  // mode: 0 = stall, 1 = always ready, 2 = random ready.
  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      logic r;
      r = (mode == 2) ? 1'($urandom) : 1'(mode);
      out_ready = r;
      tick();
      if (r) hist.push_back(next_word());
      chk("run_out_valid", 155'(out_valid), 155'(1));
      chk("run_out_data", 155'(out_data), 155'(hist[$]));
      chk("run_taps", tap_vectors, exp_taps());
    end
    out_ready = 1'b0;
  endtask

  vec_t tbl [6];

  initial begin
    logic [DEPTH*WIDTH-1:0] t0;
    logic [WIDTH-1:0]       w0;

    tbl[0] = '{{31'd478163327, 31'd107420369, 31'd1181241943, 31'd1051802512,
                31'd958682846}, 31'd1528435895, 1'b0};
    tbl[1] = '{{31'd5, 31'd4, 31'd3, 31'd2, 31'd1}, 31'd1, 1'b0};
    tbl[2] = '{{31'd0, 31'd0, 31'd0, 31'd0, 31'd0}, 31'd0, 1'b1};
    tbl[3] = '{{31'd0, 31'd0, 31'd0, 31'd0, 31'd1}, 31'd1, 1'b0};
    tbl[4] = '{{31'd5, 31'd0, 31'd0, 31'd0, 31'd0}, 31'd5, 1'b0};
    tbl[5] = '{{5{31'h7FFFFFFF}}, 31'h7FFFFFFF, 1'b0};

    // Reset values.
    #2;
    chk("rst_seed_ready", 155'(seed_ready), 155'(0));
    chk("rst_seed_err", 155'(seed_err), 155'(0));
    chk("rst_out_valid", 155'(out_valid), 155'(0));
    chk("rst_out_data", 155'(out_data), 155'(0));
    chk("rst_taps", tap_vectors, 155'(0));
    #20;
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_seed_ready", 155'(seed_ready), 155'(0));

    // Table-driven seeds.
    for (int i = 0; i < 6; i++) begin
      load_seed(tbl[i].seeds, bit'(i % 2));
      if (tbl[i].err) begin
        for (int c = 0; c < 4; c++) begin
          chk("zero_seed_err", 155'(seed_err), 155'(1));
          chk("zero_out_valid", 155'(out_valid), 155'(0));
          chk("zero_seed_ready", 155'(seed_ready), 155'(0));
          tick();
        end
      end else begin
        chk("no_seed_err", 155'(seed_err), 155'(0));
        enter_run();
        chk("first_out_data_const", 155'(out_data), 155'(tbl[i].first));
      end
    end

    // Known vector, stall for 10 cycles, then 3 back-to-back accepts.
    load_seed(tbl[0].seeds, 1'b0);
    enter_run();
    t0 = tap_vectors;
    w0 = out_data;
    run_cycles(10, 0);
    chk("stall_out_data", 155'(out_data), 155'(31'd1528435895));
    chk("stall_taps", tap_vectors, t0);
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b1;
      tick();
      hist.push_back(next_word());
      chk("b2b_out_data", 155'(out_data), 155'(hist[$]));
      chk("b2b_distinct", 155'(out_data != w0), 155'(1));
      w0 = out_data;
    end
    out_ready = 1'b0;

    // Zero seed, then a new start clears seed_err.
    load_seed(tbl[2].seeds, 1'b0);
    tick();
    chk("zero_err_sticky", 155'(seed_err), 155'(1));
    pulse_start();

    // Restart from RUN with out_ready high; a seed offer in RUN is ignored.
    load_seed(tbl[0].seeds, 1'b0);
    enter_run();
    out_ready  = 1'b1;
    start      = 1'b1;
    seed_valid = 1'b1;
    seed_data  = 31'h777;
    tick();
    start      = 1'b0;
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    chk("restart_out_valid", 155'(out_valid), 155'(0));
    chk("restart_seed_ready", 155'(seed_ready), 155'(1));
    hist.delete();
    for (int k = 1; k <= 5; k++) feed_word(WIDTH'(k));
    enter_run();
    chk("restart_first_word", 155'(out_data), 155'(1));

    // Start coinciding with a seed handshake in LOAD: that word is dropped.
    pulse_start();
    feed_word(31'd9);
    feed_word(31'd9);
    start      = 1'b1;
    seed_valid = 1'b1;
    seed_data  = 31'h777;
    tick();
    start      = 1'b0;
    seed_valid = 1'b0;
    hist.delete();
    for (int k = 1; k <= 4; k++) feed_word(WIDTH'(k));
    chk("start_drop_still_loading", 155'(seed_ready), 155'(1));
    feed_word(31'd5);
    enter_run();
    chk("start_drop_first_word", 155'(out_data), 155'(1));

    // Reset in the middle of loading.
    pulse_start();
    for (int k = 0; k < 3; k++) feed_word(tbl[0].seeds[k*WIDTH +: WIDTH]);
    rst_n = 1'b0;
    #1;
    chk("midrst_seed_ready", 155'(seed_ready), 155'(0));
    chk("midrst_seed_err", 155'(seed_err), 155'(0));
    chk("midrst_out_valid", 155'(out_valid), 155'(0));
    chk("midrst_out_data", 155'(out_data), 155'(0));
    chk("midrst_taps", tap_vectors, 155'(0));
    #12;
    rst_n = 1'b1;
    seed_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("postrst_seed_ready", 155'(seed_ready), 155'(0));
      chk("postrst_out_valid", 155'(out_valid), 155'(0));
    end
    seed_valid = 1'b0;

    // Seed with gaps reproduces the known vector.
    load_seed(tbl[0].seeds, 1'b1);
    enter_run();
    chk("gaps_known_vector", 155'(out_data), 155'(31'd1528435895));

    // Randomized seeds and random consumer back-pressure.
    for (int r = 0; r < 6; r++) begin
      logic [DEPTH*WIDTH-1:0] s;
      for (int k = 0; k < DEPTH; k++) s[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      load_seed(s, 1'b1);
      if (s == '0) begin
        chk("rand_zero_err", 155'(seed_err), 155'(1));
      end else begin
        enter_run();
        run_cycles(30, 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
